// File: rtl/instr_queue.sv
// Instruction buffer between fetcher and decoder: paces one outstanding fetch,
// statically predicts each fetched word's next PC and queues entries for decode.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear_flag_in,
  output logic        if_fetch_enable_out,
  input  logic        if_result_enable_in,
  input  logic [31:0] if_instr_in,
  input  logic [31:0] if_pc_in,
  output logic        if_write_pc_sig_out,
  output logic [31:0] if_write_pc_val_out,
  output logic        dec_valid_out,
  input  logic        dec_ready_in,
  output logic [31:0] dec_instr_out,
  output logic [31:0] dec_pc_out,
  output logic [31:0] dec_pred_pc_out,
  output logic        dec_pred_taken_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PCWR = 2'd2
  } state_t;

  state_t           state_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;
  logic             drop_pending_r;
  logic             fetch_en_r;
  logic             wpc_sig_r;
  logic [31:0]      wpc_val_r;

  logic [31:0]      instr_mem_r [DEPTH];
  logic [31:0]      pc_mem_r    [DEPTH];
  logic [31:0]      pred_mem_r  [DEPTH];
  logic [DEPTH-1:0] taken_mem_r;

  logic             flush_s;
  logic             deq_s;
  logic             enq_s;
  logic             room_s;
  logic             issue_s;
  logic [32:0]      pred_s;

  // Returns {taken, next_pc}: JAL and backward branches are predicted taken.
  function automatic logic [32:0] predict_next(input logic [31:0] instr, input logic [31:0] pc);
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [32:0] res;
    j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    case (instr[6:0])
      7'b1101111: res = {1'b1, pc + j_imm};
      7'b1100011: begin
        if (instr[31]) begin
          res = {1'b1, pc + b_imm};
        end else begin
          res = {1'b0, pc + 32'd4};
        end
      end
      default:    res = {1'b0, pc + 32'd4};
    endcase
    return res;
  endfunction

  assign dec_valid_out      = (count_r != {(PTR_W+1){1'b0}});
  assign dec_instr_out      = dec_valid_out ? instr_mem_r[head_r] : 32'd0;
  assign dec_pc_out         = dec_valid_out ? pc_mem_r[head_r]    : 32'd0;
  assign dec_pred_pc_out    = dec_valid_out ? pred_mem_r[head_r]  : 32'd0;
  assign dec_pred_taken_out = dec_valid_out ? taken_mem_r[head_r] : 1'b0;

  // Strobes are held frozen under rdy low and masked so the fetcher sees each pulse once.
  assign if_fetch_enable_out = fetch_en_r & rdy;
  assign if_write_pc_sig_out = wpc_sig_r & rdy;
  assign if_write_pc_val_out = wpc_val_r;

  assign flush_s = clear_flag_in & rdy;
  assign deq_s   = dec_valid_out & dec_ready_in & rdy & ~clear_flag_in;
  assign enq_s   = rdy & ~clear_flag_in & (state_r == ST_WAIT) & if_result_enable_in & ~drop_pending_r;
  assign room_s  = (count_r < (PTR_W+1)'(DEPTH)) | deq_s;
  assign issue_s = rdy & ~clear_flag_in & (state_r == ST_IDLE) & ~drop_pending_r & room_s;
  assign pred_s  = predict_next(if_instr_in, if_pc_in);

  // FIFO payload storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      instr_mem_r[tail_r] <= if_instr_in;
      pc_mem_r[tail_r]    <= if_pc_in;
      pred_mem_r[tail_r]  <= pred_s[31:0];
      taken_mem_r[tail_r] <= pred_s[32];
    end
  end

  // Fetch pacing FSM, FIFO pointers, drop tracking and registered fetcher strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      head_r         <= {PTR_W{1'b0}};
      tail_r         <= {PTR_W{1'b0}};
      count_r        <= {(PTR_W+1){1'b0}};
      drop_pending_r <= 1'b0;
      fetch_en_r     <= 1'b0;
      wpc_sig_r      <= 1'b0;
      wpc_val_r      <= 32'd0;
    end else if (!rdy) begin
      state_r <= state_r;
    end else if (flush_s) begin
      state_r        <= ST_IDLE;
      head_r         <= {PTR_W{1'b0}};
      tail_r         <= {PTR_W{1'b0}};
      count_r        <= {(PTR_W+1){1'b0}};
      fetch_en_r     <= 1'b0;
      wpc_sig_r      <= 1'b0;
      // An outstanding request whose response has not yet arrived must be swallowed later.
      drop_pending_r <= ((state_r == ST_WAIT) | drop_pending_r) & ~if_result_enable_in;
    end else begin
      fetch_en_r <= issue_s;
      wpc_sig_r  <= enq_s;
      if (enq_s) begin
        wpc_val_r <= pred_s[31:0];
        tail_r    <= tail_r + PTR_W'(1'b1);
      end
      if (deq_s) begin
        head_r <= head_r + PTR_W'(1'b1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
      if (drop_pending_r && if_result_enable_in) begin
        drop_pending_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: if (issue_s) state_r <= ST_WAIT;
        ST_WAIT: if (enq_s)   state_r <= ST_PCWR;
        ST_PCWR: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_queue.md
# instr_queue

Instruction buffer directly downstream of the instruction fetcher. It paces fetches with one outstanding request at a time and holds fetched instructions in a circular FIFO. It statically predicts the next PC of each fetched instruction and writes that PC back into the fetcher. Its head entry is presented to the decoder with a valid/ready handshake, and the whole queue is flushed on a pipeline clear.

## Interface
- DEPTH, 8: FIFO entries, power of two, ≥2
- PTR_W, 3: log2(DEPTH)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global ready; low freezes all state
- clear_flag_in  in  1  pipeline flush (mispredict/exception)
- if_fetch_enable_out  out  1  one-cycle fetch request to fetcher
- if_result_enable_in  in  1  fetched word valid this cycle
- if_instr_in  in  32  fetched instruction
- if_pc_in  in  32  address of fetched instruction
- if_write_pc_sig_out  out  1  one-cycle PC overwrite strobe to fetcher
- if_write_pc_val_out  out  32  predicted next PC
- dec_valid_out  out  1  head entry valid (= !empty, combinational from state)
- dec_ready_in  in  1  decoder accepts head
- dec_instr_out  out  32  head instruction
- dec_pc_out  out  32  head PC
- dec_pred_pc_out  out  32  head predicted next PC
- dec_pred_taken_out  out  1  head predicted taken

## Operation
- Entry = {instr, pc, pred_pc, pred_taken}. head/tail pointers PTR_W bits, wrap modulo DEPTH; count 0..DEPTH (PTR_W+1 bits).
- FSM states:
  - IDLE: issue request if count < DEPTH and !clear_flag_in → pulse if_fetch_enable_out, go WAIT.
  - WAIT: on if_result_enable_in, enqueue at tail, pulse if_write_pc_sig_out with pred_pc, go PCWR.
  - PCWR: go IDLE. No request is issued in PCWR.
- Prediction, 32-bit wrapping add on if_pc_in, immediates sign-extended:
  - opcode 1101111 (JAL): pred_pc = pc + J-imm, taken = 1.
  - opcode 1100011 (branch) with instr[31]=1 (backward): pred_pc = pc + B-imm, taken = 1.
  - otherwise: pred_pc = pc + 4, taken = 0 (JALR included).
- Dequeue when dec_valid_out & dec_ready_in & rdy: head++, count--. Simultaneous enqueue and dequeue leaves count unchanged.
- Credit: only one request is in flight, and a request needs count < DEPTH, so an enqueue never meets a full FIFO.
- Flush (clear_flag_in & rdy):
  - head = tail = count = 0; go IDLE; both strobes low next cycle.
  - A response arriving in the flush cycle is discarded.
  - If flush happens in WAIT with no response that cycle, set drop_pending. The next if_result_enable_in is then discarded with no enqueue and no write_pc, and drop_pending clears. No request is issued while drop_pending = 1.
  - The fetcher loads its own PC from the clear target; this block never writes PC on flush.
- Dequeue in the flush cycle is ignored.
- rdy = 0: no state, pointer or FSM change; if_fetch_enable_out and if_write_pc_sig_out driven 0; responses arriving while rdy = 0 are lost (fetcher holds its result only with rdy).
- Reset: all outputs 0; head = tail = count = 0; state IDLE; drop_pending = 0; FIFO contents don't-care.

## Timing
- All outputs are registered, except the dec_* signals, which are read combinationally from the head entry.
- Request pulse: asserted the cycle after the block enters IDLE, provided the conditions hold; exactly one cycle wide.
- Enqueue latency: response at edge N → entry visible on dec_* and if_write_pc_sig_out high in cycle N+1 → earliest next request in cycle N+3 (after PCWR). The fetcher's PC is therefore updated before the next request.
- Empty to decoder: dec_valid_out rises in the cycle after the enqueue edge; no bypass.
- Full: count = DEPTH holds the FSM in IDLE; a dequeue re-enables the request the next cycle.

## Test plan
- Reset then rdy = 1, respond to each request 1 cycle later with addi at pc 0, 4, 8 … → write_pc values 4, 8, 12, …; decoder sees pc 0, 4, 8 in order, pred_taken = 0.
- JAL at pc 0x100 with imm +0x40 → if_write_pc_val_out = 0x140, dec_pred_taken_out = 1. Backward beq at 0x200 with imm −8 → 0x1F8. Forward beq with imm +8 → 0x204, taken = 0.
- dec_ready_in = 0, keep responding → exactly DEPTH = 8 entries; no 9th request. Pulse ready for one cycle → one dequeue, then one new request and fill to 8 again; pointer wraparound preserves order.
- Flush while in WAIT, response arrives 2 cycles later → no enqueue, no write_pc; dec_valid_out = 0; the following request and response enqueue normally.
- Flush coincident with a response and a dequeue → count = 0, nothing enqueued, state IDLE next cycle.
- rdy low for 5 cycles mid-WAIT, plus async rst pulse mid-operation → state frozen during rdy low; rst immediately zeroes all outputs and count.
